// File: rtl/matrix_serial_receiver_pkg.sv
// Shared types and the cathode-field decoder for the LED matrix link receiver.
package matrix_pkg;

  localparam int MATRIX_N = 16;
  localparam int WORD_W   = 32;

  typedef logic [1:0] pixel_t;
  typedef logic [3:0] col_idx_t;

  typedef struct packed {
    logic     valid;
    col_idx_t idx;
  } col_dec_t;

  // Column c drives its cathode low on bit 15-c; exactly one low bit is a valid field.
  function automatic col_dec_t onecold_decode(input logic [15:0] cath);
    col_dec_t r;
    int       zeros;
    r     = '0;
    zeros = 0;
    for (int p = 0; p < 16; p++) begin
      if (!cath[p]) begin
        zeros = zeros + 1;
        r.idx = col_idx_t'(15 - p);
      end
    end
    r.valid = (zeros == 1);
    return r;
  endfunction

endpackage

// File: rtl/matrix_serial_receiver_link_sync.sv
// Multi-flop synchronizer for one asynchronous link input, with a registered rising-edge pulse.
module link_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign dout = sync_q[SYNC_STAGES-1];
  assign rise = rise_q;

endmodule

// File: rtl/matrix_serial_receiver.sv
// Receiving end of the 16x16 LED matrix link: emulates the 74HC595 chain, decodes
// column/anode words, accumulates density passes and rebuilds the 2-bit frame buffer.
module matrix_serial_receiver
  import matrix_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PASSES      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_clk,
  input  logic       serial_data,
  input  logic       rclk,
  input  logic       clear,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_pix,
  output logic       col_commit,
  output logic [3:0] commit_col,
  output logic       frame_done,
  output logic       err_col
);

  localparam logic [1:0] PASS_LAST = 2'(PASSES - 1);

  logic sclk_sync, sclk_rise, data_sync, rclk_sync_unused, rclk_rise, clear_sync;
  logic data_rise_unused, clear_rise_unused;

  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(serial_clk), .dout(sclk_sync), .rise(sclk_rise));
  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .din(serial_data), .dout(data_sync), .rise(data_rise_unused));
  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rclk (
    .clk(clk), .rst_n(rst_n), .din(rclk), .dout(rclk_sync_unused), .rise(rclk_rise));
  link_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clear (
    .clk(clk), .rst_n(rst_n), .din(clear), .dout(clear_sync), .rise(clear_rise_unused));

  logic [WORD_W-1:0]   shift_reg_q, shift_reg_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                latch_vld_q, latch_vld_d;
  pixel_t              acc_q [MATRIX_N][MATRIX_N];
  pixel_t              acc_d [MATRIX_N][MATRIX_N];
  logic [1:0]          pass_q [MATRIX_N];
  logic [1:0]          pass_d [MATRIX_N];
  pixel_t              fb_q [MATRIX_N*MATRIX_N];
  pixel_t              fb_d [MATRIX_N*MATRIX_N];
  logic [MATRIX_N-1:0] seen_q, seen_d, seen_next;
  pixel_t              rd_pix_q, rd_pix_d;
  logic                col_commit_q, col_commit_d;
  col_idx_t            commit_col_q, commit_col_d;
  logic                frame_done_q, frame_done_d;
  logic                err_col_q, err_col_d;
  col_dec_t            dec;
  pixel_t              sum [MATRIX_N];

  always_comb begin
    shift_reg_d  = shift_reg_q;
    word_d       = word_q;
    latch_vld_d  = 1'b0;
    acc_d        = acc_q;
    pass_d       = pass_q;
    fb_d         = fb_q;
    seen_d       = seen_q;
    seen_next    = seen_q;
    col_commit_d = 1'b0;
    commit_col_d = commit_col_q;
    frame_done_d = 1'b0;
    err_col_d    = 1'b0;
    dec          = onecold_decode(word_q[15:0]);
    for (int y = 0; y < MATRIX_N; y++) begin
      sum[y] = '0;
    end

    if (!clear_sync) begin
      shift_reg_d = '0;
    end else if (sclk_rise) begin
      shift_reg_d = {shift_reg_q[WORD_W-2:0], data_sync};
    end

    // The latch captures the pre-shift register, matching the 595 storage stage.
    if (rclk_rise) begin
      word_d      = shift_reg_q;
      latch_vld_d = 1'b1;
    end

    if (latch_vld_q) begin
      if (!dec.valid) begin
        err_col_d = 1'b1;
      end else begin
        for (int y = 0; y < MATRIX_N; y++) begin
          sum[y] = (acc_q[dec.idx][y] == 2'd3) ? 2'd3
                 : acc_q[dec.idx][y] + {1'b0, word_q[16+y]};
        end
        if (pass_q[dec.idx] == PASS_LAST) begin
          pass_d[dec.idx] = '0;
          for (int y = 0; y < MATRIX_N; y++) begin
            fb_d[{dec.idx, 4'(y)}] = sum[y];
            acc_d[dec.idx][y]      = '0;
          end
          col_commit_d = 1'b1;
          commit_col_d = dec.idx;
          seen_next    = seen_q | (16'h1 << dec.idx);
          if (&seen_next) begin
            frame_done_d = 1'b1;
            seen_d       = '0;
          end else begin
            seen_d = seen_next;
          end
        end else begin
          pass_d[dec.idx] = pass_q[dec.idx] + 2'd1;
          for (int y = 0; y < MATRIX_N; y++) begin
            acc_d[dec.idx][y] = sum[y];
          end
        end
      end
    end

    rd_pix_d = fb_q[{rd_x, rd_y}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg_q  <= '0;
      word_q       <= '0;
      latch_vld_q  <= 1'b0;
      seen_q       <= '0;
      rd_pix_q     <= '0;
      col_commit_q <= 1'b0;
      commit_col_q <= '0;
      frame_done_q <= 1'b0;
      err_col_q    <= 1'b0;
      for (int c = 0; c < MATRIX_N; c++) begin
        pass_q[c] <= '0;
        for (int y = 0; y < MATRIX_N; y++) begin
          acc_q[c][y] <= '0;
        end
      end
      for (int i = 0; i < MATRIX_N*MATRIX_N; i++) begin
        fb_q[i] <= '0;
      end
    end else begin
      shift_reg_q  <= shift_reg_d;
      word_q       <= word_d;
      latch_vld_q  <= latch_vld_d;
      acc_q        <= acc_d;
      pass_q       <= pass_d;
      fb_q         <= fb_d;
      seen_q       <= seen_d;
      rd_pix_q     <= rd_pix_d;
      col_commit_q <= col_commit_d;
      commit_col_q <= commit_col_d;
      frame_done_q <= frame_done_d;
      err_col_q    <= err_col_d;
    end
  end

  assign rd_pix     = rd_pix_q;
  assign col_commit = col_commit_q;
  assign commit_col = commit_col_q;
  assign frame_done = frame_done_q;
  assign err_col    = err_col_q;

endmodule
